// File: rtl/keypad_pkg.sv
// Shared types and the key map for the scanned hex keypad.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_res_t;

    // Indexed {row, col}; row 3 carries *, 0, # and D.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Frame-level press/release debouncer producing one accept per keypress.
//  state    | meaning
//  IDLE     | no key held, waiting for a single-key frame
//  DEBOUNCE | counting consecutive frames of the candidate key
//  PRESSED  | key accepted, waiting for an empty frame
//  RELEASE  | counting consecutive empty frames before re-arming
module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end_i,
    input  frame_res_t res_i,
    input  logic [3:0] code_i,
    output logic       accept_o,
    output logic       key_pressed_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    kp_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic          kp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            kp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            kp_q    <= (state_d == PRESSED) || (state_d == RELEASE);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        accept_o = 1'b0;
        if (frame_end_i) begin
            case (state_q)
                IDLE: begin
                    if (res_i == SINGLE) begin
                        cand_d = code_i;
                        cnt_d  = CNT_ONE;
                        if (CNT_MAX == CNT_ONE) begin
                            accept_o = 1'b1;
                            state_d  = PRESSED;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (res_i == SINGLE && code_i == cand_q) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_MAX) begin
                            accept_o = 1'b1;
                            state_d  = PRESSED;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (res_i == NONE) begin
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_MAX == CNT_ONE) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (res_i == NONE) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_MAX) state_d = IDLE;
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign key_pressed_o = kp_q;

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 keypad scanner with frame debounce and a 6-digit hex entry register.
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_COUNT     = 50_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_sense,
    input  logic        clear,
    output logic [3:0]  col_drive,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_pressed,
    output logic [23:0] hex_value,
    output logic [2:0]  digit_count
);

    localparam int SW = $clog2(SCAN_COUNT);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_COUNT - 1);

    logic [3:0]    row_s1_q, row_s2_q;
    logic [SW-1:0] slot_q;
    logic [1:0]    col_q;
    logic [15:0]   frame_q;
    logic          frame_end_q;
    logic          key_valid_q;
    logic [3:0]    key_code_q;
    logic [23:0]   hex_q;
    logic [2:0]    cnt_q;

    logic          sample;
    logic [4:0]    nbits;
    logic [3:0]    fr_code;
    frame_res_t    fr_res;
    logic          accept;

    assign sample = (slot_q == SLOT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            slot_q      <= '0;
            col_q       <= '0;
            frame_q     <= '0;
            frame_end_q <= 1'b0;
        end else begin
            row_s1_q    <= row_sense;
            row_s2_q    <= row_s1_q;
            frame_end_q <= sample && (col_q == 2'd3);
            if (sample) begin
                slot_q <= '0;
                col_q  <= col_q + 2'd1;
                for (int r = 0; r < 4; r++)
                    frame_q[r*4 + int'(col_q)] <= ~row_s2_q[r];
            end else begin
                slot_q <= slot_q + SW'(1);
            end
        end
    end

    // Last set bit supplies the code; it is only used when exactly one is set.
    always_comb begin
        nbits   = '0;
        fr_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_q[i]) begin
                nbits   = nbits + 5'd1;
                fr_code = KEY_MAP[i];
            end
        end
        if (nbits == 5'd0)      fr_res = NONE;
        else if (nbits == 5'd1) fr_res = SINGLE;
        else                    fr_res = MULTI;
    end

    keypad_debounce_fsm #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .frame_end_i  (frame_end_q),
        .res_i        (fr_res),
        .code_i       (fr_code),
        .accept_o     (accept),
        .key_pressed_o(key_pressed)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            hex_q       <= '0;
            cnt_q       <= '0;
        end else begin
            key_valid_q <= accept;
            if (accept) key_code_q <= fr_code;
            if (clear) begin
                hex_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                hex_q <= {hex_q[19:0], fr_code};
                if (cnt_q != 3'd6) cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign col_drive   = ~(4'b0001 << col_q);
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign hex_value   = hex_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural keypad matrix.
module tb_hex_keypad_entry;

    localparam int SC    = 8;
    localparam int DS    = 2;
    localparam int FRAME = 4 * SC;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  row_sense;
    logic [3:0]  col_drive;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic [23:0] hex_value;
    logic [2:0]  digit_count;
    logic [15:0] keys_down;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int kp_cycles = 0;

    typedef struct {
        logic [15:0] keys;
        int          on_f;
        int          off_f;
        int          exp_pulses;
        logic [3:0]  code;
        logic [23:0] hex;
        logic [2:0]  cnt;
        logic        kp_seen;
    } vec_t;

    vec_t tv [12];

    hex_keypad_entry #(
        .SCAN_COUNT    (SC),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row_sense  (row_sense),
        .clear      (clear),
        .col_drive  (col_drive),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_pressed(key_pressed),
        .hex_value  (hex_value),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // A held key pulls its row low while its column is driven low.
    always_comb begin
        row_sense = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !col_drive[c]) row_sense[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid)   pulses++;
            if (key_pressed) kp_cycles++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at the first negedge of a new frame (column 0 just driven).
    task automatic align();
        int n = 0;
        while (col_drive !== 4'b0111 && n < 200) begin @(negedge clk); n++; end
        while (col_drive !== 4'b1110 && n < 400) begin @(negedge clk); n++; end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL align: got timeout expected frame start");
        end
    endtask

    task automatic hold(input logic [15:0] k, input int nf);
        keys_down = k;
        repeat (nf * FRAME) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, k0;
        tv[0]  = '{16'h0040, 12, 3, 1, 4'h6, 24'h000006, 3'd1, 1'b1};
        tv[1]  = '{16'h0001,  3, 3, 1, 4'h1, 24'h000061, 3'd2, 1'b1};
        tv[2]  = '{16'h0002,  3, 3, 1, 4'h2, 24'h000612, 3'd3, 1'b1};
        tv[3]  = '{16'h0004,  3, 3, 1, 4'h3, 24'h006123, 3'd4, 1'b1};
        tv[4]  = '{16'h0008,  3, 3, 1, 4'hA, 24'h06123A, 3'd5, 1'b1};
        tv[5]  = '{16'h0080,  3, 3, 1, 4'hB, 24'h6123AB, 3'd6, 1'b1};
        tv[6]  = '{16'h0800,  3, 3, 1, 4'hC, 24'h123ABC, 3'd6, 1'b1};
        tv[7]  = '{16'h0100,  3, 3, 1, 4'h7, 24'h23ABC7, 3'd6, 1'b1};
        tv[8]  = '{16'h0001,  1, 3, 0, 4'h7, 24'h23ABC7, 3'd6, 1'b0};
        tv[9]  = '{16'h0003,  5, 3, 0, 4'h7, 24'h23ABC7, 3'd6, 1'b0};
        tv[10] = '{16'h2000,  3, 3, 1, 4'h0, 24'h3ABC70, 3'd6, 1'b1};
        tv[11] = '{16'h4000,  3, 3, 1, 4'hF, 24'hABC70F, 3'd6, 1'b1};

        reset = 1'b1; clear = 1'b0; keys_down = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (13) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst col_drive", 32'(col_drive), 32'hE);
        chk("rst key_valid", 32'(key_valid), 32'h0);
        chk("rst key_code", 32'(key_code), 32'h0);
        chk("rst key_pressed", 32'(key_pressed), 32'h0);
        chk("rst hex_value", 32'(hex_value), 32'h0);
        chk("rst digit_count", 32'(digit_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("scan col0", 32'(col_drive), 32'hE);
        repeat (8) @(negedge clk);
        chk("scan col1", 32'(col_drive), 32'hD);
        repeat (8) @(negedge clk);
        chk("scan col2", 32'(col_drive), 32'hB);
        repeat (8) @(negedge clk);
        chk("scan col3", 32'(col_drive), 32'h7);

        for (int i = 0; i < 12; i++) begin
            align();
            p0 = pulses;
            k0 = kp_cycles;
            hold(tv[i].keys, tv[i].on_f);
            hold(16'h0, tv[i].off_f);
            chk($sformatf("v%0d pulses", i), 32'(pulses - p0), 32'(tv[i].exp_pulses));
            chk($sformatf("v%0d key_code", i), 32'(key_code), 32'(tv[i].code));
            chk($sformatf("v%0d hex_value", i), 32'(hex_value), 32'(tv[i].hex));
            chk($sformatf("v%0d digit_count", i), 32'(digit_count), 32'(tv[i].cnt));
            chk($sformatf("v%0d kp_seen", i), 32'(kp_cycles != k0), 32'(tv[i].kp_seen));
            chk($sformatf("v%0d kp_end", i), 32'(key_pressed), 32'h0);
        end

        // Release needs DS empty frames before key_pressed drops.
        align();
        p0 = pulses;
        hold(16'h0020, 3);
        keys_down = '0;
        repeat (48) @(negedge clk);
        chk("rel 1 frame kp", 32'(key_pressed), 32'h1);
        repeat (32) @(negedge clk);
        chk("rel 2 frames kp", 32'(key_pressed), 32'h0);
        repeat (16) @(negedge clk);
        hold(16'h0020, 3);
        hold(16'h0, 1);
        hold(16'h0020, 3);
        chk("repress pulses", 32'(pulses - p0), 32'd2);
        chk("repress kp", 32'(key_pressed), 32'h1);
        hold(16'h0, 2);
        hold(16'h0020, 3);
        hold(16'h0, 3);
        chk("repress2 pulses", 32'(pulses - p0), 32'd3);
        chk("repress hex", 32'(hex_value), 32'h70F555);

        // clear lands on the same edge as the accept.
        align();
        keys_down = 16'h0200;
        repeat (64) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr key_valid", 32'(key_valid), 32'h1);
        chk("clr hex_value", 32'(hex_value), 32'h0);
        chk("clr digit_count", 32'(digit_count), 32'h0);
        chk("clr key_code", 32'(key_code), 32'h8);
        hold(16'h0, 3);
        hold(16'h0200, 3);
        hold(16'h0, 3);
        chk("post clr hex", 32'(hex_value), 32'h000008);
        chk("post clr count", 32'(digit_count), 32'h1);

        // Reset while the candidate is still debouncing.
        align();
        keys_down = 16'h0010;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("dbrst kp", 32'(key_pressed), 32'h0);
        chk("dbrst col", 32'(col_drive), 32'hE);
        chk("dbrst hex", 32'(hex_value), 32'h0);
        chk("dbrst code", 32'(key_code), 32'h0);
        keys_down = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        p0 = pulses;
        hold(16'h0, 3);
        chk("dbrst pulses", 32'(pulses - p0), 32'd0);
        chk("dbrst kp idle", 32'(key_pressed), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_keypad_entry.md
# hex_keypad_entry

Scanned 4x4 matrix-keypad input block: drives keypad columns one at a time, samples rows, debounces over whole scan frames, and emits one pulse per accepted keypress. Accepted hex digits shift into a 24-bit value. That value is sized to feed the 6-digit seven-segment display path directly, so operands and addresses can be entered on the board.

## Interface
- SCAN_COUNT, 50_000: clk cycles per column slot (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical frames needed to accept a press or confirm a release; minimum 1.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- row_sense  in  4  keypad rows, active-low, external pull-ups, asynchronous to clk.
- clear  in  1  synchronous clear of hex_value and digit_count.
- col_drive  out  4  keypad columns, active-low, exactly one low at all times.
- key_valid  out  1  one-cycle pulse per accepted key.
- key_code  out  4  code of last accepted key, held until the next one.
- key_pressed  out  1  high in PRESSED/RELEASE states.
- hex_value  out  24  entered digits, newest in [3:0].
- digit_count  out  3  digits entered since clear/reset, saturates at 6.

## Operation
- row_sense passes through a 2-FF synchronizer before any use.
- Column counter col (0..3) advances when slot counter reaches SCAN_COUNT-1, wrapping 3→0; col_drive = ~(1<<col).
- Rows are sampled into a 16-bit frame vector at slot count SCAN_COUNT-1 of each column. A frame ends at the col 3 sample.
- Frame result: NONE (0 bits set), SINGLE K (exactly 1 bit set), MULTI (≥2 bits set). MULTI is treated as "not K" in every state and never produces a key.
- Key map, row r / col c → code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- FSM, evaluated only at frame end:
  - IDLE: SINGLE K → DEBOUNCE, cand=K, cnt=1 (if DEBOUNCE_SCANS=1, accept immediately).
  - DEBOUNCE: same K → cnt+1; when cnt reaches DEBOUNCE_SCANS, accept → PRESSED. Anything else → IDLE.
  - PRESSED: NONE → RELEASE, cnt=1. Otherwise stay; no auto-repeat, and a different key while held is ignored.
  - RELEASE: NONE → cnt+1; when cnt reaches DEBOUNCE_SCANS → IDLE. Anything else → PRESSED, with no new pulse.
- Accept: key_valid=1 for one cycle, key_code=cand, hex_value={hex_value[19:0],cand}, digit_count=min(digit_count+1,6). All four update on the same edge.
- clear: hex_value=0 and digit_count=0. Clear wins over a simultaneous accept; key_valid and key_code still update. clear does not affect the FSM or the scan.
- Reset, including mid-debounce or mid-press: all counters 0, col=0, FSM IDLE.
  - Output reset values: col_drive=4'b1110, key_valid=0, key_code=0, key_pressed=0, hex_value=0, digit_count=0.

## Timing
- Frame length = 4*SCAN_COUNT cycles.
- Row settle time = SCAN_COUNT-1 cycles after a column switch.
- Synchronizer latency = 2 cycles. This is absorbed by the settle time and needs no compensation.
- key_valid asserts on the clk edge after the sample that completes the DEBOUNCE_SCANS-th matching frame.
- Press-to-pulse latency: from first full frame with the key stable, DEBOUNCE_SCANS frames plus 1 cycle.
- The minimum gap between two key_valid pulses is 2*DEBOUNCE_SCANS frames.
- key_pressed is registered and changes on the FSM-update edge.

## Structure
- Package keypad_pkg holds:
  - the state enum (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - the frame-result enum;
  - the 16-entry key-map constant array, indexed {r,c}.
- Sub-module keypad_debounce_fsm: takes the frame-end strobe plus frame result/code, and produces accept and key_pressed.
- The top level holds the synchronizer, scan counters, frame vector and entry register.

## Test plan
Sim parameters: SCAN_COUNT=8, DEBOUNCE_SCANS=2.
- Reset asserted mid-frame → col_drive=1110 and all outputs 0. After release, col_drive cycles 1110,1101,1011,0111 every 8 cycles.
- Hold r1c2 for 12 frames → exactly one key_valid, key_code=6, hex_value=0x000006, digit_count=1; key_pressed high until 2 NONE frames after release.
- Enter 1,2,3,A,B,C,7, each held 3 frames and released 3 frames → hex_value=0x23ABC7, digit_count=6.
- Press r0c0 for 1 frame only → no key_valid. Press r0c0+r0c1 together for 5 frames → no key_valid, FSM stays IDLE.
- In PRESSED, release 1 frame then re-press → no second pulse. Release 2 frames then press → second pulse.
- Assert clear on the key_valid cycle → hex_value=0, digit_count=0, key_code updated. Assert reset during DEBOUNCE → no pulse, IDLE.
